// File: rtl/alu_issue_wb.sv
// alu_issue_wb: issue/writeback stage wrapped around a 16-bit ALU.
// Accepts one instruction per handshake, reads operands from an internal
// register file, holds them on the ALU inputs, captures the ALU result and
// writes it back along with the zero flag.
// Optional feature macro: ALU_ISSUE_DBG_PORT_EN adds a combinational
// register-file read port (dbg_addr / dbg_data).
module alu_issue_wb #(
  parameter  int DATA_W = 16,
  parameter  int NREG   = 8,
  localparam int AW     = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [AW-1:0]     instr_rd,
  input  logic [AW-1:0]     instr_rs1,
  input  logic [AW-1:0]     instr_rs2,
  input  logic              instr_imm_sel,
  input  logic [7:0]        instr_imm,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_z,
  output logic              wb_valid,
  output logic [AW-1:0]     wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              z_flag
`ifdef ALU_ISSUE_DBG_PORT_EN
  ,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WAIT = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   in1_q, in2_q;
  logic [2:0]          op_q;
  logic [AW-1:0]       rd_q;
  logic [DATA_W-1:0]   result_q;
  logic                zres_q;
  logic                z_flag_q;
  logic [DATA_W-1:0]   rf_q [NREG];
  logic                accept;

  // State register; reset abandons any in-flight instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake/writeback strobes; fixed 4-cycle sequence.
  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    wb_valid    = 1'b0;
    accept      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        instr_ready = 1'b1;
        accept      = instr_valid;
        if (instr_valid) state_d = ST_EXEC;
      end
      ST_EXEC: state_d = ST_WAIT;
      ST_WAIT: state_d = ST_WB;
      ST_WB: begin
        wb_valid = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand/opcode/destination capture, only on acceptance; held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in1_q <= '0;
      in2_q <= '0;
      op_q  <= '0;
      rd_q  <= '0;
    end else if (accept) begin
      in1_q <= rf_q[instr_rs1];
      in2_q <= instr_imm_sel ? {{(DATA_W-8){1'b0}}, instr_imm} : rf_q[instr_rs2];
      op_q  <= instr_op;
      rd_q  <= instr_rd;
    end
  end

  // Sample the ALU two edges after acceptance so a registered ALU also fits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      zres_q   <= 1'b0;
    end else if (state_q == ST_WAIT) begin
      result_q <= alu_out;
      zres_q   <= alu_z;
    end
  end

  // Architectural zero flag commits together with the register write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    z_flag_q <= 1'b0;
    else if (state_q == ST_WB)  z_flag_q <= zres_q;
  end

  // Register file: flops so the whole array clears on reset; R0 is writable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (state_q == ST_WB) begin
      rf_q[rd_q] <= result_q;
    end
  end

  assign alu_in1 = in1_q;
  assign alu_in2 = in2_q;
  assign alu_op  = op_q;
  assign wb_rd   = rd_q;
  assign wb_data = result_q;
  assign z_flag  = z_flag_q;

`ifdef ALU_ISSUE_DBG_PORT_EN
  assign dbg_data = rf_q[dbg_addr];
`endif

endmodule

// File: doc/alu_issue_wb.md
# alu_issue_wb

Issue/writeback stage wrapped around the 16-bit ALU. Accepts one decoded instruction at a time over a valid/ready handshake and reads two operands from an internal 8 x 16-bit register file. Presents `in1`/`in2`/`alu_op` to the ALU and holds them stable, captures `alu_out`/`z`, then writes the result back to the register file and the zero flag. It is the block directly upstream of the ALU (operand feed) and directly downstream of it (result consumer).

## Interface
- `DATA_W`, 16, datapath width; must match the ALU.
- `NREG`, 8, register count; address width is clog2(NREG) = 3.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `instr_valid`  in  1  decoded instruction present.
- `instr_ready`  out  1  high only in IDLE; transfer occurs when valid && ready at the rising edge.
- `instr_op`  in  3  ALU opcode, passed through unmodified.
- `instr_rd`, `instr_rs1`, `instr_rs2`  in  3 each  destination and source register indices.
- `instr_imm_sel`  in  1  1: operand 2 is the immediate; 0: operand 2 is R[rs2].
- `instr_imm`  in  8  immediate, zero-extended to DATA_W.
- `alu_in1`, `alu_in2`  out  16  registered operands driven to the ALU.
- `alu_op`  out  3  registered opcode driven to the ALU.
- `alu_out`  in  16  ALU result.
- `alu_z`  in  1  ALU zero indication.
- `wb_valid`  out  1  high for exactly one cycle, in WB.
- `wb_rd`  out  3  destination index for the pending write.
- `wb_data`  out  16  result being written.
- `z_flag`  out  1  architectural zero flag.

## Operation
- Register file: NREG x DATA_W. All entries reset to 0. R0 is an ordinary writable register.
- The block is opcode-agnostic; it never decodes `alu_op`.
- FSM states: IDLE, EXEC, WAIT, WB.
  - IDLE: `instr_ready`=1. On handshake:
    - latch `rd`;
    - `alu_in1` <= R[rs1];
    - `alu_in2` <= `imm_sel` ? {8'b0, imm} : R[rs2];
    - `alu_op` <= `instr_op`;
    - go to EXEC.
  - EXEC: operands held. Go to WAIT.
  - WAIT: operands held. At the edge, result <= `alu_out`, zres <= `alu_z`. Go to WB.
  - WB: `wb_valid`=1, `wb_data`=result, `wb_rd`=latched rd. At the edge:
    - R[rd] <= result;
    - `z_flag` <= zres;
    - go to IDLE.
- Operand reads happen only at acceptance. rs1 == rs2 == rd is legal; the read sees the old value.
- `instr_valid` while not ready is ignored; no buffering.
- The `alu_in*` and `alu_op` outputs keep their last values in IDLE and change only on acceptance.

## Timing
- Reset values: state=IDLE, `instr_ready`=1, `alu_in1`=`alu_in2`=0, `alu_op`=0, `wb_valid`=0, `wb_rd`=0, `wb_data`=0, `z_flag`=0, all registers 0.
- Acceptance at edge T0:
  - ALU inputs are valid from T0.
  - `alu_out` is sampled at T2. This covers both a combinational and a one-cycle-registered ALU.
  - `wb_valid` is high during T2..T3.
  - Register and `z_flag` update at T3.
  - `instr_ready` is high again after T3.
- Throughput: one instruction per 4 cycles. With `instr_valid` held high, acceptances occur at T0, T4, T8, ...
- `rst` asserted in any state:
  - immediate return to reset values;
  - the in-flight instruction is discarded with no write;
  - the register file is cleared.

## Configuration
- `ALU_ISSUE_DBG_PORT_EN`
- Defined: adds ports `dbg_addr` (in, 3) and `dbg_data` (out, 16).
  - `dbg_data` = R[dbg_addr], combinational.
  - Updated values are visible the cycle after the WB edge.
- Undefined: ports absent; no additional logic.
- Core behaviour is identical in both cases.

## Test plan
The bench uses an ALU model with op 0 = ADD, op 1 = SUB, and z = (out == 0). `ALU_ISSUE_DBG_PORT_EN` is defined.
- Reset: pulse `rst` mid-clock -> all outputs at reset values immediately; `instr_ready`=1; `dbg_data`=0 for every address.
- Immediate load: op=0, rd=1, rs1=0, imm_sel=1, imm=6 -> `alu_in1`=0 and `alu_in2`=6 from T0; `wb_valid` high one cycle with `wb_rd`=1 and `wb_data`=6; R1=6 after T3. Repeat with rd=2, imm=2 -> R2=2.
- Register-register: op=1, rd=3, rs1=1, rs2=2 -> `alu_in1`=6, `alu_in2`=2, `alu_op`=1; R3=4; `z_flag`=0.
- Zero result: op=1, rd=4, rs1=2, rs2=2 -> `wb_data`=0; R4=0; `z_flag`=1 after T3. A following op=0, rd=5, rs1=1, rs2=2 -> R5=8 and `z_flag` returns to 0.
- Back-to-back: `instr_valid` held high with 3 queued instructions -> accepted exactly at T0, T4, T8; `instr_ready` low for 3 cycles after each acceptance.
- Reset in WAIT during op=0, rd=6, imm=9 -> no `wb_valid` pulse; R6=0; state IDLE; the next instruction completes normally.
